mvm_issue: RTL and testbench

Instruction-driven issue sequencer that feeds one MVM `datapath` lane. It accepts row instructions into a small FIFO and joins a vector-chunk stream with a weight-chunk stream. It then drives the datapath's per-beat controls: operand data, accumulation address, accumulate, last and reduce. It is the initiator side of the datapath's unhandshaked input interface and sits between the MVM tile controller/buffers and each `datapath` instance.

---
 rtl/mvm_issue_if.sv | 60 ++++++
 rtl/mvm_issue.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mvm_issue.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_issue_if.sv
// mvm_issue_if
// Bundles the traffic around one mvm_issue sequencer:
//   - instruction handshake and row descriptor (inst_*)
//   - vector-chunk stream (vec_*)
//   - weight-chunk stream (wgt_*)
//   - registered datapath controls (valid, dataa, datab, datac, accum_addr,
//     accum, last, reduce)
//   - status pulses and level (done, inst_err, busy)
// The master modport is the side that feeds instructions/streams and
// observes the datapath controls; the slave modport is the sequencer itself.
interface mvm_issue_if #(
  parameter int DATAW = 512,
  parameter int IPREC = 8,
  parameter int ADDRW = 9,
  parameter int CNTW  = 8
);
  // instruction channel
  logic             inst_valid;
  logic             inst_ready;
  logic [ADDRW-1:0] inst_addr;
  logic [CNTW-1:0]  inst_chunks;
  logic             inst_accum;
  logic             inst_release;
  logic             inst_reduce;
  logic [IPREC-1:0] inst_datac;
  // vector and weight chunk streams
  logic             vec_valid;
  logic             vec_ready;
  logic [DATAW-1:0] vec_data;
  logic             wgt_valid;
  logic             wgt_ready;
  logic [DATAW-1:0] wgt_data;
  // datapath controls
  logic             valid;
  logic [DATAW-1:0] dataa;
  logic [DATAW-1:0] datab;
  logic [IPREC-1:0] datac;
  logic [ADDRW-1:0] accum_addr;
  logic             accum;
  logic             last;
  logic             reduce;
  // status
  logic             done;
  logic             inst_err;
  logic             busy;

  modport master (
    output inst_valid, inst_addr, inst_chunks, inst_accum, inst_release,
           inst_reduce, inst_datac, vec_valid, vec_data, wgt_valid, wgt_data,
    input  inst_ready, vec_ready, wgt_ready, valid, dataa, datab, datac,
           accum_addr, accum, last, reduce, done, inst_err, busy
  );

  modport slave (
    input  inst_valid, inst_addr, inst_chunks, inst_accum, inst_release,
           inst_reduce, inst_datac, vec_valid, vec_data, wgt_valid, wgt_data,
    output inst_ready, vec_ready, wgt_ready, valid, dataa, datab, datac,
           accum_addr, accum, last, reduce, done, inst_err, busy
  );
endinterface

// File: rtl/mvm_issue.sv
// mvm_issue
// Issue sequencer for one MVM datapath lane. Row instructions are queued in a
// small FIFO; the active row joins the vector and weight chunk streams beat by
// beat and drives registered datapath controls (operands, accumulation
// address, accumulate/last/reduce flags). Rows follow each other with no
// bubble when the next queued row is valid; zero-chunk rows are dropped with a
// one-cycle inst_err pulse.
// Ports:
//   clk  - single clock domain
//   rst  - asynchronous, active-low reset
//   bus  - mvm_issue_if.slave: instruction handshake, vec/wgt streams,
//          datapath controls, done/inst_err pulses and busy level
module mvm_issue #(
  parameter int LANES       = 64,
  parameter int IPREC       = 8,
  parameter int DATAW       = LANES * IPREC,
  parameter int MEM_DEPTH   = 512,
  parameter int ADDRW       = $clog2(MEM_DEPTH),
  parameter int CNTW        = 8,
  parameter int IFIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  mvm_issue_if.slave bus
);

  localparam int PTRW = $clog2(IFIFO_DEPTH);
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [PTRW:0]   LVL_ONE  = {{PTRW{1'b0}}, 1'b1};
  localparam logic [PTRW:0]   LVL_FULL = (PTRW+1)'(IFIFO_DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE  = {{(PTRW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [CNTW-1:0]  chunks;
    logic             accum;
    logic             rel_last;
    logic             reduce;
    logic [IPREC-1:0] datac;
  } inst_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // FIFO storage and pointers; the level counter is one bit wider than the
  // pointers so full and empty stay distinct after pointer wrap-around.
  inst_t           fifo_mem_r [IFIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic [PTRW:0]   level_r;
  logic            ready_en_r;

  // active row and beat counter
  inst_t           cur_r;
  logic [CNTW-1:0] k_r;
  state_t          state_r;
  state_t          state_nxt_s;

  // datapath output registers
  logic             valid_r;
  logic [DATAW-1:0] dataa_r;
  logic [DATAW-1:0] datab_r;
  logic [IPREC-1:0] datac_r;
  logic [ADDRW-1:0] addr_r;
  logic             accum_r;
  logic             last_r;
  logic             reduce_r;
  logic             done_r;
  logic             err_r;

  // combinational control
  inst_t head_s;
  logic  empty_s;
  logic  full_s;
  logic  head_zero_s;
  logic  push_s;
  logic  pop_s;
  logic  load_s;
  logic  err_s;
  logic  fire_s;
  logic  last_k_s;
  logic  final_s;
  logic  vec_ready_s;
  logic  wgt_ready_s;

  assign head_s      = fifo_mem_r[rd_ptr_r];
  assign empty_s     = (level_r == {(PTRW+1){1'b0}});
  assign full_s      = (level_r == LVL_FULL);
  assign head_zero_s = (head_s.chunks == CNT_ZERO);
  // a push into a full FIFO is refused even when a pop happens the same edge
  assign push_s      = bus.inst_valid & ~full_s & ready_en_r;
  assign last_k_s    = (k_r == (cur_r.chunks - CNT_ONE));

  // Holds inst_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Instruction FIFO storage, pointers and fill level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IFIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      level_r  <= {(PTRW+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= '{addr:     bus.inst_addr,
                                  chunks:   bus.inst_chunks,
                                  accum:    bus.inst_accum,
                                  rel_last: bus.inst_release,
                                  reduce:   bus.inst_reduce,
                                  datac:    bus.inst_datac};
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && !head_zero_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // a zero-chunk head is left for IDLE to drop and flag
        if (final_s && (empty_s || head_zero_s)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: readies, fire, and FIFO pop/load decisions.
  always_comb begin
    pop_s       = 1'b0;
    load_s      = 1'b0;
    err_s       = 1'b0;
    fire_s      = 1'b0;
    final_s     = 1'b0;
    vec_ready_s = 1'b0;
    wgt_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s  = 1'b1;
          err_s  = head_zero_s;
          load_s = ~head_zero_s;
        end else begin
          pop_s  = 1'b0;
        end
      end
      ST_ISSUE: begin
        // each stream is offered ready only when its partner is valid, so
        // both are consumed together or neither is
        vec_ready_s = bus.wgt_valid;
        wgt_ready_s = bus.vec_valid;
        fire_s      = bus.vec_valid & bus.wgt_valid;
        final_s     = fire_s & last_k_s;
        if (final_s && !empty_s && !head_zero_s) begin
          pop_s  = 1'b1;
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // Active row descriptor and beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_r <= '0;
      k_r   <= CNT_ZERO;
    end else begin
      if (load_s) begin
        cur_r <= head_s;
        k_r   <= CNT_ZERO;
      end else if (fire_s) begin
        k_r   <= k_r + CNT_ONE;
      end
    end
  end

  // Registered datapath controls; operand/address fields hold between beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r  <= 1'b0;
      dataa_r  <= {DATAW{1'b0}};
      datab_r  <= {DATAW{1'b0}};
      datac_r  <= {IPREC{1'b0}};
      addr_r   <= {ADDRW{1'b0}};
      accum_r  <= 1'b0;
      last_r   <= 1'b0;
      reduce_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      valid_r  <= fire_s;
      last_r   <= fire_s & cur_r.rel_last & last_k_s;
      reduce_r <= fire_s & cur_r.reduce & last_k_s;
      done_r   <= final_s;
      err_r    <= err_s;
      if (fire_s) begin
        dataa_r <= bus.vec_data;
        datab_r <= bus.wgt_data;
        datac_r <= cur_r.datac;
        addr_r  <= cur_r.addr;
        // later beats of a row always accumulate onto the first
        accum_r <= cur_r.accum | (k_r != CNT_ZERO);
      end
    end
  end

  assign bus.inst_ready = ready_en_r & ~full_s;
  assign bus.vec_ready  = vec_ready_s;
  assign bus.wgt_ready  = wgt_ready_s;
  assign bus.valid      = valid_r;
  assign bus.dataa      = dataa_r;
  assign bus.datab      = datab_r;
  assign bus.datac      = datac_r;
  assign bus.accum_addr = addr_r;
  assign bus.accum      = accum_r;
  assign bus.last       = last_r;
  assign bus.reduce     = reduce_r;
  assign bus.done       = done_r;
  assign bus.inst_err   = err_r;
  assign bus.busy       = ~empty_s | (state_r == ST_ISSUE);

endmodule

// File: tb/tb_mvm_issue.sv
// tb_mvm_issue
// Randomized bench for mvm_issue. Each accepted instruction is expanded into
// its expected list of beats; each joined stream handshake records the chunk
// pair it carried. Every datapath beat is matched against both, and the beat
// timing is checked against the cycle in which the streams were consumed.
module tb_mvm_issue;
  localparam int DATAW = 512;
  localparam int IPREC = 8;
  localparam int ADDRW = 9;
  localparam int CNTW  = 8;

  typedef logic [DATAW-1:0] w_t;

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic             accum;
    logic             last;
    logic             reduce;
    logic             done;
    logic [IPREC-1:0] datac;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mvm_issue_if #(.DATAW(DATAW), .IPREC(IPREC), .ADDRW(ADDRW), .CNTW(CNTW)) bus ();

  mvm_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  beat_t exp_q[$];
  w_t    vq[$];
  w_t    wq[$];

  int unsigned vec_pct = 0;
  int unsigned wgt_pct = 0;
  bit          wgt_alt = 1'b0;
  int unsigned seed_v  = 0;
  int unsigned seed_w  = 0;
  bit          vec_hs  = 1'b0;
  bit          wgt_hs  = 1'b0;
  bit          prev_fire = 1'b0;
  int beats = 0, dones = 0, errs = 0, exp_dones = 0, exp_errs = 0;

  task automatic check(input string tag, input w_t obs, input w_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic w_t gen(input int unsigned seed, input int unsigned idx);
    w_t d;
    for (int i = 0; i < DATAW / 32; i++) begin
      d[i*32 +: 32] = (seed ^ (idx * 32'h9E3779B1)) + (i * 32'h7F4A7C15);
    end
    return d;
  endfunction

  // vector stream driver: a chunk stays on the bus until it is consumed
  initial begin
    int unsigned idx = 0;
    bus.vec_valid = 1'b0;
    bus.vec_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (vec_hs) idx++;
      bus.vec_valid = ($urandom_range(99) < vec_pct);
      bus.vec_data  = gen(seed_v, idx);
    end
  end

  // weight stream driver: random or strictly alternating valid
  initial begin
    int unsigned idx = 0;
    bus.wgt_valid = 1'b0;
    bus.wgt_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (wgt_hs) idx++;
      if (wgt_alt) bus.wgt_valid = ~bus.wgt_valid;
      else         bus.wgt_valid = ($urandom_range(99) < wgt_pct);
      bus.wgt_data = gen(seed_w, idx);
    end
  end

  // monitor and reference model, sampled on the falling edge
  initial begin
    beat_t e;
    bit    ok;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete(); vq.delete(); wq.delete();
        prev_fire = 1'b0; vec_hs = 1'b0; wgt_hs = 1'b0;
        exp_dones = dones; exp_errs = errs;
      end else begin
        check("valid_timing", w_t'(bus.valid), w_t'(prev_fire));
        if (bus.valid) begin
          beats++;
          ok = (exp_q.size() != 0) && (vq.size() != 0) && (wq.size() != 0);
          check("beat_expected", w_t'(ok), w_t'(1'b1));
          if (ok) begin
            e = exp_q.pop_front();
            check("addr",   w_t'(bus.accum_addr), w_t'(e.addr));
            check("accum",  w_t'(bus.accum),      w_t'(e.accum));
            check("last",   w_t'(bus.last),       w_t'(e.last));
            check("reduce", w_t'(bus.reduce),     w_t'(e.reduce));
            check("done",   w_t'(bus.done),       w_t'(e.done));
            check("datac",  w_t'(bus.datac),      w_t'(e.datac));
            check("dataa",  bus.dataa,            vq.pop_front());
            check("datab",  bus.datab,            wq.pop_front());
          end
        end else begin
          check("idle_flags", w_t'({bus.last, bus.reduce, bus.done}), w_t'(3'b000));
        end
        if (bus.done) dones++;
        if (bus.inst_err) errs++;
        check("vec_ready_join", w_t'(bus.vec_ready & ~bus.wgt_valid), w_t'(1'b0));
        check("wgt_ready_join", w_t'(bus.wgt_ready & ~bus.vec_valid), w_t'(1'b0));
        vec_hs = bus.vec_valid & bus.vec_ready;
        wgt_hs = bus.wgt_valid & bus.wgt_ready;
        check("joint_consume", w_t'(vec_hs), w_t'(wgt_hs));
        prev_fire = vec_hs & wgt_hs;
        if (vec_hs) vq.push_back(bus.vec_data);
        if (wgt_hs) wq.push_back(bus.wgt_data);
        if (bus.inst_valid && bus.inst_ready) begin
          if (bus.inst_chunks == '0) begin
            exp_errs++;
          end else begin
            exp_dones++;
            for (int k = 0; k < int'(bus.inst_chunks); k++) begin
              e.addr   = bus.inst_addr;
              e.accum  = bus.inst_accum || (k > 0);
              e.last   = bus.inst_release && (k == int'(bus.inst_chunks) - 1);
              e.reduce = bus.inst_reduce && (k == int'(bus.inst_chunks) - 1);
              e.done   = (k == int'(bus.inst_chunks) - 1);
              e.datac  = bus.inst_datac;
              exp_q.push_back(e);
            end
          end
        end
      end
    end
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic push(input logic [ADDRW-1:0] a, input logic [CNTW-1:0] n,
                      input logic acc, input logic rel, input logic red,
                      input logic [IPREC-1:0] dc, output int waited);
    bit taken = 1'b0;
    waited = 0;
    bus.inst_valid = 1'b1; bus.inst_addr = a; bus.inst_chunks = n;
    bus.inst_accum = acc; bus.inst_release = rel; bus.inst_reduce = red;
    bus.inst_datac = dc;
    for (int t = 0; t < 300 && !taken; t++) begin
      @(negedge clk);
      taken = bus.inst_ready;
      if (!taken) waited++;
      @(posedge clk); #1;
    end
    bus.inst_valid = 1'b0;
    check("push_accepted", w_t'(taken), w_t'(1'b1));
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 1'b0;
    for (int t = 0; t < budget && !idle; t++) begin
      @(negedge clk); #1;
      idle = (exp_q.size() == 0) && !bus.busy;
    end
    check("drain", w_t'(idle), w_t'(1'b1));
    check("no_ready_idle", w_t'(bus.vec_ready | bus.wgt_ready), w_t'(1'b0));
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, w_t'({bus.valid, bus.accum, bus.last, bus.reduce, bus.done,
                     bus.inst_err, bus.busy, bus.accum_addr, bus.datac}), w_t'(0));
    check(tag, bus.dataa | bus.datab, w_t'(0));
  endtask

  initial begin
    int w, b0, d0, e0, cnt;
    bit seen;
    seed_v = $urandom; seed_w = $urandom;
    bus.inst_valid = 1'b0; bus.inst_addr = '0; bus.inst_chunks = '0;
    bus.inst_accum = 1'b0; bus.inst_release = 1'b0; bus.inst_reduce = 1'b0;
    bus.inst_datac = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_ready", w_t'(bus.inst_ready), w_t'(1'b1));
    check_all_zero("post_reset");
    @(posedge clk); #1;

    // single row, both streams always valid
    vec_pct = 100; wgt_pct = 100;
    b0 = beats; d0 = dones;
    push(9'd5, 8'd3, 1'b0, 1'b1, 1'b1, 8'h11, w);
    wait_idle(100);
    check("single_beats", w_t'(beats - b0), w_t'(3));
    check("single_done", w_t'(dones - d0), w_t'(1));

    // join stalls: weights on alternate cycles
    wgt_alt = 1'b1; b0 = beats;
    push(9'd9, 8'd4, 1'b0, 1'b1, 1'b0, 8'h22, w);
    wait_idle(100);
    wgt_alt = 1'b0;
    check("join_beats", w_t'(beats - b0), w_t'(4));

    // back-to-back: queue up with streams off until full
    vec_pct = 0; wgt_pct = 0;
    repeat (3) @(posedge clk); #1;
    b0 = beats; d0 = dones;
    push(9'd0, 8'd1, 1'b0, 1'b1, 1'b0, 8'h30, w);
    push(9'd1, 8'd2, 1'b0, 1'b1, 1'b1, 8'h31, w);
    push(9'd2, 8'd1, 1'b1, 1'b0, 1'b0, 8'h32, w);
    push(9'd3, 8'd4, 1'b0, 1'b1, 1'b0, 8'h33, w);
    push(9'd4, 8'd2, 1'b0, 1'b0, 1'b1, 8'h34, w);
    @(negedge clk);
    check("full_not_ready", w_t'(bus.inst_ready), w_t'(1'b0));
    @(posedge clk); #1;
    cnt = 0; seen = 1'b0;
    fork
      begin
        vec_pct = 100; wgt_pct = 100;
        push(9'd5, 8'd1, 1'b0, 1'b1, 1'b0, 8'h35, w);
        check("held_push", w_t'(w > 0), w_t'(1'b1));
      end
      begin
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk); #1;
          seen = bus.valid;
        end
        check("b2b_start", w_t'(seen), w_t'(1'b1));
        cnt = 1;
        repeat (10) begin
          @(negedge clk); #1;
          if (bus.valid) cnt++;
        end
      end
    join
    check("b2b_no_bubble", w_t'(cnt), w_t'(11));
    wait_idle(100);
    check("b2b_done", w_t'(dones - d0), w_t'(6));

    // zero-chunk instruction is dropped
    b0 = beats; e0 = errs;
    push(9'd3, 8'd0, 1'b0, 1'b1, 1'b1, 8'h40, w);
    push(9'd7, 8'd1, 1'b0, 1'b1, 1'b0, 8'h41, w);
    wait_idle(100);
    check("zero_err", w_t'(errs - e0), w_t'(1));
    check("zero_beats", w_t'(beats - b0), w_t'(1));

    // accumulate continuation
    b0 = beats; d0 = dones;
    push(9'd11, 8'd2, 1'b1, 1'b0, 1'b0, 8'h50, w);
    wait_idle(100);
    check("cont_beats", w_t'(beats - b0), w_t'(2));
    check("cont_done", w_t'(dones - d0), w_t'(1));

    // reset in the middle of a row with two rows queued
    vec_pct = 0; wgt_pct = 0;
    repeat (3) @(posedge clk); #1;
    push(9'd20, 8'd5, 1'b0, 1'b1, 1'b1, 8'h60, w);
    push(9'd21, 8'd2, 1'b0, 1'b1, 1'b0, 8'h61, w);
    push(9'd22, 8'd3, 1'b0, 1'b1, 1'b0, 8'h62, w);
    b0 = beats; vec_pct = 100; wgt_pct = 100;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk); #1;
      seen = (beats - b0 >= 2);
    end
    check("mid_beat2", w_t'(seen), w_t'(1'b1));
    #1 rst = 1'b0;
    #1 check_all_zero("async_reset");
    check("reset_no_ready", w_t'({bus.inst_ready, bus.vec_ready, bus.wgt_ready}), w_t'(0));
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rel_ready", w_t'(bus.inst_ready), w_t'(1'b1));
    check("rel_busy", w_t'(bus.busy), w_t'(1'b0));
    b0 = beats;
    repeat (10) @(negedge clk);
    #1 check("rel_no_beats", w_t'(beats - b0), w_t'(0));
    @(posedge clk); #1;

    // randomized rows and stream stalls
    for (int i = 0; i < 40; i++) begin
      vec_pct = $urandom_range(100, 30);
      wgt_pct = $urandom_range(100, 30);
      push(ADDRW'($urandom), CNTW'($urandom_range(5)), 1'($urandom),
           1'($urandom), 1'($urandom), IPREC'($urandom), w);
      repeat ($urandom_range(3)) @(posedge clk);
      #1;
    end
    vec_pct = 100; wgt_pct = 100;
    wait_idle(1000);

    check("done_count", w_t'(dones), w_t'(exp_dones));
    check("err_count", w_t'(errs), w_t'(exp_errs));
    check("queues_empty", w_t'(exp_q.size() + vq.size() + wq.size()), w_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
